// File: rtl/brew_pkg.sv
// Shared definitions for the brew sequencer: state encoding, recipe stage
// lengths and the default progress-tick divider.
package brew_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 20000000;
  localparam int unsigned PCT_W            = 7;
  localparam logic [PCT_W-1:0] PCT_MAX     = 7'd100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_GRIND = 3'd2,
    ST_PUMP  = 3'd3,
    ST_MILK  = 3'd4,
    ST_DONE  = 3'd5
  } brew_state_e;

  // Stage length in ticks for a recipe; non-brewing states have no length.
  function automatic logic [PCT_W-1:0] stage_len(input logic [1:0] drink,
                                                 input brew_state_e st);
    logic [PCT_W-1:0] len;
    len = '0;
    case (st)
      ST_HEAT: begin
        case (drink)
          2'd0, 2'd1: len = 7'd30;
          2'd2:       len = 7'd25;
          default:    len = 7'd20;
        endcase
      end
      ST_GRIND: begin
        case (drink)
          2'd2:    len = 7'd15;
          default: len = 7'd20;
        endcase
      end
      ST_PUMP: begin
        case (drink)
          2'd0:    len = 7'd50;
          2'd3:    len = 7'd20;
          default: len = 7'd30;
        endcase
      end
      ST_MILK: begin
        case (drink)
          2'd0:    len = 7'd0;
          2'd1:    len = 7'd20;
          2'd2:    len = 7'd30;
          default: len = 7'd40;
        endcase
      end
      default: len = '0;
    endcase
    return len;
  endfunction

  // First non-empty brewing stage after 'from'; DONE when none remain.
  function automatic brew_state_e next_active(input logic [1:0] drink,
                                              input brew_state_e from);
    brew_state_e nxt;
    nxt = ST_DONE;
    for (int i = 4; i >= 1; i--) begin
      if (i > int'(from) && stage_len(drink, brew_state_e'(3'(i))) != '0) begin
        nxt = brew_state_e'(3'(i));
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV cycles
// while not held in clear.
module tick_prescaler
  import brew_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick is decoded combinationally so the consumer sees it in the wrap cycle.
  assign tick = !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/brew_sequencer.sv
// Beverage brew sequencer: walks a recipe through heat/grind/pump/milk stages,
// driving one actuator per stage and reporting percent progress.
module brew_sequencer
  import brew_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       drink,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             heater_en,
  output logic             grinder_en,
  output logic             pump_en,
  output logic             milk_en,
  output logic [2:0]       stage,
  output logic [PCT_W-1:0] procent
);

  brew_state_e      state_q, state_d;
  logic [1:0]       drink_q, drink_d;
  logic [PCT_W-1:0] procent_q, procent_d;
  logic [PCT_W-1:0] scnt_q, scnt_d, scnt_inc;
  logic             aborted_d;
  logic             busy_q, done_q, aborted_q;
  logic             heater_q, grinder_q, pump_q, milk_q;
  logic [2:0]       stage_q;
  logic             active_c, clear_c, tick_c;

  assign active_c = (state_q == ST_HEAT) || (state_q == ST_GRIND) ||
                    (state_q == ST_PUMP) || (state_q == ST_MILK);
  assign clear_c  = !active_c;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_c),
    .tick  (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    drink_d   = drink_q;
    procent_d = procent_q;
    scnt_d    = scnt_q;
    aborted_d = 1'b0;
    scnt_inc  = scnt_q + 7'd1;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          drink_d   = drink;
          procent_d = '0;
          scnt_d    = '0;
          state_d   = next_active(drink, ST_IDLE);
        end
      end
      ST_HEAT, ST_GRIND, ST_PUMP, ST_MILK: begin
        // Abort takes priority over any tick or stage boundary in the same cycle.
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (tick_c) begin
          if (procent_q < PCT_MAX) begin
            procent_d = procent_q + 7'd1;
          end
          scnt_d = scnt_inc;
          if (scnt_inc >= stage_len(drink_q, state_q)) begin
            scnt_d  = '0;
            state_d = next_active(drink_q, state_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      drink_q   <= '0;
      procent_q <= '0;
      scnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      heater_q  <= 1'b0;
      grinder_q <= 1'b0;
      pump_q    <= 1'b0;
      milk_q    <= 1'b0;
      stage_q   <= '0;
    end else begin
      state_q   <= state_d;
      drink_q   <= drink_d;
      procent_q <= procent_d;
      scnt_q    <= scnt_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      aborted_q <= aborted_d;
      heater_q  <= (state_d == ST_HEAT);
      grinder_q <= (state_d == ST_GRIND);
      pump_q    <= (state_d == ST_PUMP);
      milk_q    <= (state_d == ST_MILK);
      stage_q   <= state_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign heater_en  = heater_q;
  assign grinder_en = grinder_q;
  assign pump_en    = pump_q;
  assign milk_en    = milk_q;
  assign stage      = stage_q;
  assign procent    = procent_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Self-checking bench for brew_sequencer: directed recipe scenarios plus
// randomized start/abort/reset traffic against a timeline-based reference model.
module tb_brew_sequencer;

  localparam int unsigned TD    = 4;
  localparam int unsigned T_END = 100 * TD;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] drink;
  logic       busy, done, aborted, heater_en, grinder_en, pump_en, milk_en;
  logic [2:0] stage;
  logic [6:0] procent;

  brew_sequencer #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .drink      (drink),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .heater_en  (heater_en),
    .grinder_en (grinder_en),
    .pump_en    (pump_en),
    .milk_en    (milk_en),
    .stage      (stage),
    .procent    (procent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned len_tab [4][4] = '{'{30, 20, 50, 0}, '{30, 20, 30, 20},
                                  '{25, 15, 30, 30}, '{20, 20, 20, 40}};

  // Reference model: a brew is just "cycles elapsed since start".
  bit          m_active  = 1'b0;
  bit          m_aborted = 1'b0;
  int unsigned m_k       = 0;
  int unsigned m_procent = 0;
  logic [1:0]  m_drink   = 2'd0;

  int stage_cyc [6];
  int en_cyc [4];
  int multi_en;
  int done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_stage();
    int unsigned acc = 0;
    int unsigned t;
    if (!m_active) return 0;
    if (m_k >= T_END) return 5;
    t = m_k / TD;
    for (int s = 0; s < 4; s++) begin
      acc += len_tab[m_drink][s];
      if (t < acc) return int'(s) + 1;
    end
    return 5;
  endfunction

  function automatic int unsigned exp_procent();
    return m_active ? (m_k / TD) : m_procent;
  endfunction

  function automatic logic [6:0] exp_flags();
    int unsigned st;
    st = exp_stage();
    return {m_active, m_active && (m_k == T_END), m_aborted,
            st == 1, st == 2, st == 3, st == 4};
  endfunction

  function automatic void model_update(input bit r, input bit s, input logic [1:0] d,
                                       input bit a);
    m_aborted = 1'b0;
    if (r) begin
      m_active  = 1'b0;
      m_procent = 0;
    end else if (!m_active) begin
      if (s && !a) begin
        m_active  = 1'b1;
        m_k       = 0;
        m_drink   = d;
        m_procent = 0;
      end
    end else if (m_k == T_END) begin
      m_active  = 1'b0;
      m_procent = 100;
    end else if (a) begin
      m_active  = 1'b0;
      m_aborted = 1'b1;
      m_procent = m_k / TD;
    end else begin
      m_k++;
    end
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) stage_cyc[i] = 0;
    for (int i = 0; i < 4; i++) en_cyc[i] = 0;
    multi_en = 0;
    done_cnt = 0;
  endtask

  // One clock: drive inputs, let the edge happen, then compare just after it.
  task automatic step(input bit r, input bit s, input logic [1:0] d, input bit a);
    logic [3:0] en;
    rst   = r;
    start = s;
    drink = d;
    abort = a;
    @(posedge clk);
    model_update(r, s, d, a);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    check("stage", 32'(stage), 32'(exp_stage()));
    check("procent", 32'(procent), 32'(exp_procent()));
    check("flags", 32'({busy, done, aborted, heater_en, grinder_en, pump_en, milk_en}),
          32'(exp_flags()));
    en = {heater_en, grinder_en, pump_en, milk_en};
    if (stage < 3'd6) stage_cyc[stage]++;
    if (heater_en)  en_cyc[0]++;
    if (grinder_en) en_cyc[1]++;
    if (pump_en)    en_cyc[2]++;
    if (milk_en)    en_cyc[3]++;
    if ($countones(en) > 1) multi_en++;
    if (done) done_cnt++;
  endtask

  // Runs to IDLE while throwing ignored starts at the busy sequencer.
  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
      n++;
    end
    check("brew_end_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic run_until_stage(input logic [2:0] st, input int unsigned pct, input bit use_pct);
    int n = 0;
    while (!(stage == st && (!use_pct || procent == 7'(pct))) && n < 1000) begin
      step(1'b0, 1'b0, 2'd0, 1'b0);
      n++;
    end
    check("reach_target", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    drink = 2'd0;

    step(1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 1'b1);
    check("reset_all_zero", 32'({busy, done, aborted, heater_en, grinder_en, pump_en,
                                 milk_en, stage, procent}), 32'd0);

    // Drink 0: milk stage is empty and must be skipped.
    clear_counts();
    step(1'b0, 1'b1, 2'd0, 1'b0);
    run_until_idle(1000);
    check("d0_heat_cycles", 32'(stage_cyc[1]), 32'd120);
    check("d0_grind_cycles", 32'(stage_cyc[2]), 32'd80);
    check("d0_pump_cycles", 32'(stage_cyc[3]), 32'd200);
    check("d0_milk_cycles", 32'(stage_cyc[4]), 32'd0);
    check("d0_done_pulses", 32'(done_cnt), 32'd1);
    check("d0_final_procent", 32'(procent), 32'd100);

    // Drink 3: per-actuator on-time and one-hot enables.
    clear_counts();
    step(1'b0, 1'b1, 2'd3, 1'b0);
    run_until_idle(1000);
    check("d3_heater_cycles", 32'(en_cyc[0]), 32'd80);
    check("d3_grinder_cycles", 32'(en_cyc[1]), 32'd80);
    check("d3_pump_cycles", 32'(en_cyc[2]), 32'd80);
    check("d3_milk_cycles", 32'(en_cyc[3]), 32'd160);
    check("d3_multi_enable", 32'(multi_en), 32'd0);

    // Abort in PUMP at 60%.
    step(1'b0, 1'b1, 2'd0, 1'b0);
    run_until_stage(3'd3, 60, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    check("abort_stage", 32'(stage), 32'd0);
    check("abort_pulse", 32'(aborted), 32'd1);
    check("abort_procent", 32'(procent), 32'd60);
    check("abort_enables", 32'({heater_en, grinder_en, pump_en, milk_en}), 32'd0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("abort_pulse_width", 32'(aborted), 32'd0);
    check("abort_procent_hold", 32'(procent), 32'd60);

    // Second start during GRIND must not disturb drink 1 timing.
    clear_counts();
    step(1'b0, 1'b1, 2'd1, 1'b0);
    run_until_stage(3'd2, 0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    run_until_idle(1000);
    check("d1_heat_cycles", 32'(stage_cyc[1]), 32'd120);
    check("d1_grind_cycles", 32'(stage_cyc[2]), 32'd80);
    check("d1_pump_cycles", 32'(stage_cyc[3]), 32'd120);
    check("d1_milk_cycles", 32'(stage_cyc[4]), 32'd80);

    // Start and abort together in IDLE.
    step(1'b0, 1'b1, 2'd1, 1'b1);
    check("start_abort_idle_stage", 32'(stage), 32'd0);
    check("start_abort_idle_busy", 32'(busy), 32'd0);

    // Reset mid-MILK, then a full fresh run.
    step(1'b0, 1'b1, 2'd2, 1'b0);
    run_until_stage(3'd4, 0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    check("rst_mid_milk_zero", 32'({busy, done, aborted, heater_en, grinder_en, pump_en,
                                    milk_en, stage, procent}), 32'd0);
    clear_counts();
    step(1'b0, 1'b1, 2'd2, 1'b0);
    check("restart_procent", 32'(procent), 32'd0);
    run_until_idle(1000);
    check("d2_heat_cycles", 32'(stage_cyc[1]), 32'd100);
    check("d2_grind_cycles", 32'(stage_cyc[2]), 32'd60);
    check("d2_pump_cycles", 32'(stage_cyc[3]), 32'd120);
    check("d2_milk_cycles", 32'(stage_cyc[4]), 32'd120);
    check("d2_final_procent", 32'(procent), 32'd100);

    // Random traffic.
    for (int c = 0; c < 20000; c++) begin
      step(1'($urandom_range(0, 1999) == 0), 1'($urandom_range(0, 19) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 249) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 20000000, SHALL give the clock cycles per 1% progress tick.
REQ-002 Port clk, input, 1 bit: single system clock; all logic SHALL be on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: one-cycle request to begin a brew.
REQ-005 Port drink, input, 2 bits: recipe select, sampled only in the start cycle.
REQ-006 Port abort, input, 1 bit: one-cycle request to cancel a brew.
REQ-007 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 Port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-009 Port aborted, output, 1 bit: one-cycle pulse on cancellation.
REQ-010 Port heater_en / grinder_en / pump_en / milk_en, output, 1 bit each: actuator enables.
REQ-011 Port stage, output, 3 bits: current state code.
REQ-012 Port procent, output, 7 bits: progress, 0..100.

Function
REQ-013 States SHALL be IDLE=0, HEAT=1, GRIND=2, PUMP=3, MILK=4 and DONE=5.
REQ-014 Recipe stage lengths in ticks SHALL be (heat/grind/pump/milk):
- drink 0: 30/20/50/0
- drink 1: 30/20/30/20
- drink 2: 25/15/30/30
- drink 3: 20/20/20/40
Each recipe totals 100 ticks.
REQ-015 In IDLE, start=1 and abort=0 at cycle N SHALL latch drink, clear procent, the stage counter and the prescaler, and enter HEAT at N+1 with busy=1.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 A tick SHALL occur when the prescaler reaches TICK_DIV-1; the prescaler then wraps to 0.
REQ-018 Each tick SHALL increment procent and the stage counter.
REQ-019 When the stage counter reaches the stage length, the FSM SHALL advance to the next stage and clear the stage counter, in the same cycle as the tick.
REQ-020 A stage of length 0 SHALL be skipped; no cycle is spent in it.
REQ-021 After the last non-empty stage completes, the FSM SHALL enter DONE with procent=100.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 procent SHALL hold its value in IDLE until the next accepted start or rst.
REQ-024 Enables SHALL be registered and one-hot per state:
- heater_en in HEAT only
- grinder_en in GRIND only
- pump_en in PUMP only
- milk_en in MILK only
- all 0 in IDLE and DONE
REQ-025 abort=1 in HEAT, GRIND, PUMP or MILK SHALL give, next cycle: state IDLE, all enables 0, aborted=1 for one cycle; procent keeps its last value.
REQ-026 abort in IDLE or DONE SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-027 When abort coincides with a tick or stage boundary, abort SHALL win.
REQ-028 procent SHALL never exceed 100, and the prescaler SHALL never reach TICK_DIV.

Reset
REQ-029 rst=1 SHALL set, at the next edge:
- state IDLE
- busy, done, aborted and all enables 0
- procent, stage counter, prescaler and latched drink 0
REQ-030 rst SHALL override start and abort, including mid-brew.

Structure
REQ-031 A shared package brew_pkg SHALL hold the state encoding, the recipe length table and the TICK_DIV default.
REQ-032 One sub-module, tick_prescaler, SHALL be used: clk/rst/clear inputs, a one-cycle tick output, parameter TICK_DIV.

Verification (TICK_DIV=4)
REQ-033 start, drink=0 -> HEAT 120 cycles, GRIND 80, PUMP 200, MILK never entered, then done pulse; procent=100; busy falls the cycle after done.
REQ-034 start, drink=3 -> heater/grinder/pump/milk each asserted 80/80/80/160 cycles, never two at once.
REQ-035 start, then abort during PUMP at procent=60 -> next cycle IDLE, enables 0, aborted=1 for 1 cycle, procent=60.
REQ-036 Second start during GRIND with drink=2 -> ignored; recipe timing unchanged; the start and abort same-cycle case in IDLE leaves state IDLE.
REQ-037 rst asserted mid-MILK -> next cycle all outputs 0; a new start then runs a full recipe from procent=0.
